ps2_host_tx: RTL and testbench

Host-to-device transmitter for the PS/2 keyboard port. It sends one command byte to the keyboard, such as 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset). It follows the PS/2 host-request sequence, drives the open-collector clock and data lines, and checks the device acknowledge. It sits beside the existing PS/2 `keyboard` receiver in the top level and shares PS2_KBCLK/PS2_KBDAT with it. Its `busy` output lets the top level ignore receiver output while a command is in flight.

---
 rtl/ps2_host_tx.sv | 187 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the clock, issues a request-to-send,
// shifts out {stop, parity, data} on device clock falls and checks the device acknowledge.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned REQ_CYCLES     = 50,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       psClk,
  input  logic       psData,
  output logic       psClk_oe,
  output logic       psData_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned PhMax = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int unsigned PhW   = $clog2(PhMax + 1);

  localparam logic [PhW-1:0] InhLast = PhW'(INHIBIT_CYCLES - 1);
  localparam logic [PhW-1:0] ReqLast = PhW'(REQ_CYCLES - 1);
  localparam logic [19:0]    ToLast  = 20'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StInhibit  = 3'd1;
  localparam logic [2:0] StReq      = 3'd2;
  localparam logic [2:0] StSend     = 3'd3;
  localparam logic [2:0] StAck      = 3'd4;
  localparam logic [2:0] StWaitIdle = 3'd5;

  logic [2:0]     state_q, state_d;
  logic [PhW-1:0] ph_cnt_q, ph_cnt_d;
  logic [19:0]    to_cnt_q, to_cnt_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [8:0]     sh_q, sh_d;
  logic           clk_oe_q, clk_oe_d;
  logic           dat_oe_q, dat_oe_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           clk_s1_q, clk_s2_q, clk_prev_q;
  logic           dat_s1_q, dat_s2_q;
  logic           fall;
  logic           to_hit;

  assign fall   = clk_prev_q & ~clk_s2_q;
  assign to_hit = (to_cnt_q == ToLast);

  always_comb begin
    state_d   = state_q;
    ph_cnt_d  = ph_cnt_q;
    to_cnt_d  = to_cnt_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    if (state_q == StSend || state_q == StAck || state_q == StWaitIdle) begin
      to_cnt_d = fall ? 20'd0 : to_cnt_q + 20'd1;
    end

    case (state_q)
      StIdle: begin
        if (tx_valid) begin
          sh_d      = {~^tx_data, tx_data};
          bit_cnt_d = 4'd0;
          ph_cnt_d  = '0;
          clk_oe_d  = 1'b1;
          state_d   = StInhibit;
        end
      end
      StInhibit: begin
        if (ph_cnt_q == InhLast) begin
          ph_cnt_d = '0;
          dat_oe_d = 1'b1;
          state_d  = StReq;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
      StReq: begin
        if (ph_cnt_q == ReqLast) begin
          clk_oe_d = 1'b0;
          to_cnt_d = 20'd0;
          state_d  = StSend;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
      StSend: begin
        if (to_hit) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          err_d    = 1'b1;
          state_d  = StIdle;
        end else if (fall) begin
          // A 1 is shifted in behind parity so the tenth fall presents the stop bit.
          bit_cnt_d = bit_cnt_q + 4'd1;
          dat_oe_d  = ~sh_q[0];
          sh_d      = {1'b1, sh_q[8:1]};
          if (bit_cnt_q == 4'd9) begin
            state_d = StAck;
          end
        end
      end
      StAck: begin
        if (to_hit) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          err_d    = 1'b1;
          state_d  = StIdle;
        end else if (fall) begin
          if (dat_s2_q) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StWaitIdle;
          end
        end
      end
      StWaitIdle: begin
        if (to_hit) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          err_d    = 1'b1;
          state_d  = StIdle;
        end else if (clk_s2_q && dat_s2_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        state_d  = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      ph_cnt_q   <= '0;
      to_cnt_q   <= 20'd0;
      bit_cnt_q  <= 4'd0;
      sh_q       <= 9'd0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      ph_cnt_q   <= ph_cnt_d;
      to_cnt_q   <= to_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      done_q     <= done_d;
      err_q      <= err_d;
      clk_s1_q   <= psClk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= psData;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign psClk_oe  = clk_oe_q;
  assign psData_oe = dat_oe_q;
  assign tx_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host while
// table-driven and hand-written sequences check bits, handshake, NACK, timeout and reset.
module tb_ps2_host_tx;

  localparam int TTo = 2000;  // shortened timeout keeps the run brief
  localparam int H   = 20;    // device clock half-period in Clk cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       psClk, psData;
  logic       psClk_oe, psData_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, err;

  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic last_rel = 1'b0;
  int errors = 0, checks = 0;

  // Open-collector bus: either side may pull low.
  assign psClk  = dev_clk & ~psClk_oe;
  assign psData = dev_dat & ~psData_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(5000),
    .REQ_CYCLES    (50),
    .TIMEOUT_CYCLES(TTo)
  ) dut (
    .Clk      (clk),
    .reset_n  (rst_n),
    .psClk    (psClk),
    .psData   (psData),
    .psClk_oe (psClk_oe),
    .psData_oe(psData_oe),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done && err) both_cnt++;
    if (done || err) last_rel = tx_ready & ~busy & ~psClk_oe & ~psData_oe;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    chk("tx_ready_idle", tx_ready, 1'b1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Device side of one frame; sample 0 is taken after the host releases the clock.
  task automatic dev_run(input logic ack, input int npulse, output logic [10:0] samp,
                         output int oe_hi, output int t_last);
    int n;
    samp   = '0;
    oe_hi  = 0;
    t_last = 0;
    n      = 0;
    while (!psClk_oe && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!psClk_oe) begin
      chk("inhibit_start", 32'd0, 32'd1);
      return;
    end
    while (psClk_oe && oe_hi < 20000) begin
      oe_hi++;
      @(negedge clk);
    end
    repeat (H) @(negedge clk);
    samp[0] = psData;
    for (int k = 1; k <= npulse && k <= 10; k++) begin
      t_last  = cyc;
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      samp[k] = psData;
      repeat (H) @(negedge clk);
    end
    if (npulse > 10) begin
      dev_dat = ~ack;
      repeat (2) @(negedge clk);
      t_last  = cyc;
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      dev_dat = 1'b1;
    end
  endtask

  task automatic wait_result(input int base);
    int n;
    n = 0;
    while (done_cnt + err_cnt <= base && n < TTo + 500) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt + err_cnt <= base) chk("result_wait", 32'd0, 32'd1);
    repeat (8) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       ack;
    logic       par;
    logic       exp_done;
    logic       exp_err;
  } vec_t;

  vec_t       tbl[6];
  logic [10:0] samp, samp2;
  int         oe_hi, t_last, d0, e0, n, t_err;
  logic       prev_busy;

  initial begin
    tbl[0] = '{8'hED, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{8'hF4, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{8'h55, 1'b0, 1'b1, 1'b0, 1'b1};  // device NACK

    repeat (3) @(negedge clk);
    chk("rst_clk_oe", psClk_oe, 1'b0);
    chk("rst_dat_oe", psData_oe, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tx_ready", tx_ready, 1'b1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      send(tbl[i].data);
      dev_run(tbl[i].ack, 11, samp, oe_hi, t_last);
      wait_result(d0 + e0);
      chk("inhibit_len", oe_hi, 5050);
      chk("frame_bits", samp, {1'b1, tbl[i].par, tbl[i].data, 1'b0});
      chk("done_pulses", done_cnt - d0, tbl[i].exp_done);
      chk("err_pulses", err_cnt - e0, tbl[i].exp_err);
      chk("release_at_pulse", last_rel, 1'b1);
    end

    // Timeout: device stops after four clock pulses.
    d0 = done_cnt;
    send(8'h5A);
    dev_run(1'b1, 4, samp, oe_hi, t_last);
    n = 0;
    while (!err && n < TTo + 100) begin
      @(negedge clk);
      n++;
    end
    t_err = cyc;
    chk("timeout_seen", err, 1'b1);
    // fall is acted on 3 edges after the pin drops; err follows TTo cycles later
    chk("timeout_latency", t_err - t_last, TTo + 3);
    chk("timeout_clk_oe", psClk_oe, 1'b0);
    chk("timeout_dat_oe", psData_oe, 1'b0);
    chk("timeout_tx_ready", tx_ready, 1'b1);
    repeat (4) @(negedge clk);
    chk("timeout_no_done", done_cnt - d0, 0);

    // Reset mid-frame after fall 5, then a clean 0xF4 frame.
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h3C);
    dev_run(1'b1, 5, samp, oe_hi, t_last);
    chk("pre_reset_busy", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_clk_oe", psClk_oe, 1'b0);
    chk("reset_dat_oe", psData_oe, 1'b0);
    chk("reset_busy", busy, 1'b0);
    repeat (20) @(negedge clk);
    chk("reset_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
    d0 = done_cnt;
    send(8'hF4);
    dev_run(1'b1, 11, samp, oe_hi, t_last);
    wait_result(d0 + err_cnt);
    chk("after_reset_bits", samp, {1'b1, 1'b0, 8'hF4, 1'b0});
    chk("after_reset_done", done_cnt - d0, 1);

    // tx_valid held: 0xFF frame, data changed during inhibit, back-to-back accept.
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h00;
    dev_run(1'b1, 11, samp, oe_hi, t_last);
    prev_busy = busy;
    n = 0;
    while (!done && n < 200) begin
      prev_busy = busy;
      @(negedge clk);
      n++;
    end
    chk("held_done_seen", done, 1'b1);
    chk("held_busy_before", prev_busy, 1'b1);
    chk("held_busy_gap", busy, 1'b0);
    chk("held_ready_gap", tx_ready, 1'b1);
    @(negedge clk);
    tx_valid = 1'b0;
    chk("held_busy_after", busy, 1'b1);
    chk("held_first_bits", samp, {1'b1, 1'b1, 8'hFF, 1'b0});
    dev_run(1'b1, 11, samp2, oe_hi, t_last);
    wait_result(d0 + e0 + 1);
    chk("held_second_bits", samp2, {1'b1, 1'b1, 8'h00, 1'b0});
    chk("held_done_count", done_cnt - d0, 2);
    chk("held_err_count", err_cnt - e0, 0);
    chk("done_err_overlap", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
